// File: rtl/qspi_flash_responder.sv
// Single-lane SPI mode-0 flash responder: serves READ (0x03) from a req/ack memory
// port and READ-ID (0x9F) from a parameter, with all SPI pins oversampled on clock.
module qspi_flash_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        underrun,
  output logic        bad_cmd
);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_ID   = 8'h9F;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_IGNORE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic        sck_prev, cs_prev;
  logic        sck_s, cs_s, mosi_s;
  logic        sck_rise, sck_fall, cs_fall;
  logic [22:0] rx;
  logic [23:0] shift_in;
  logic [7:0]  tx;
  logic [4:0]  bit_cnt;
  logic [2:0]  fall_cnt;
  logic [1:0]  id_idx;
  logic [7:0]  pf_data;
  logic        pf_valid;
  logic [23:0] rd_addr;
  logic        ack_take, ack_fresh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign shift_in = {rx, mosi_s};

  // An ack only counts as fresh data if it answers the byte the next boundary needs;
  // acks for skipped (underrun) bytes or aborted frames are dropped.
  assign ack_take  = mem_ack & mem_req;
  assign ack_fresh = ack_take && (mem_addr == rd_addr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (cs_fall) state_next = S_CMD;
        S_CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            if (shift_in[7:0] == OP_READ)    state_next = S_ADDR;
            else if (shift_in[7:0] == OP_ID) state_next = S_ID;
            else                             state_next = S_IGNORE;
          end
        end
        S_ADDR: if (sck_rise && bit_cnt == 5'd23) state_next = S_DATA;
        default: ;
      endcase
    end
  end

  assign spi_miso_oe = (state == S_DATA) || (state == S_ID);
  assign spi_miso    = spi_miso_oe ? tx[7] : 1'b1;
  assign busy        = (state != S_IDLE) && !cs_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx       <= '0;
      tx       <= '0;
      bit_cnt  <= '0;
      fall_cnt <= '0;
      id_idx   <= '0;
      pf_data  <= '0;
      pf_valid <= 1'b0;
      rd_addr  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      underrun <= 1'b0;
      bad_cmd  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      bad_cmd  <= 1'b0;
      // The handshake always completes, even if the frame that issued it is gone.
      if (ack_take) begin
        mem_req <= 1'b0;
        if (state == S_DATA && !cs_s && ack_fresh && !(sck_fall && fall_cnt == 3'd0)) begin
          pf_data  <= mem_rdata;
          pf_valid <= 1'b1;
        end
      end
      if (cs_s) begin
        bit_cnt  <= '0;
        fall_cnt <= '0;
        pf_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: bit_cnt <= '0;
          S_CMD: begin
            if (sck_rise) begin
              rx <= shift_in[22:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                fall_cnt <= '0;
                if (shift_in[7:0] == OP_ID) begin
                  tx     <= JEDEC_ID[23:16];
                  id_idx <= '0;
                end else if (shift_in[7:0] != OP_READ) begin
                  bad_cmd <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              rx <= shift_in[22:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                fall_cnt <= '0;
                rd_addr  <= shift_in;
                pf_valid <= 1'b0;
                if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_addr <= shift_in;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_DATA: begin
            if (sck_fall) begin
              fall_cnt <= fall_cnt + 3'd1;
              if (fall_cnt == 3'd0) begin
                // The address advances even on underrun so a late byte is never re-sent.
                rd_addr <= rd_addr + 24'd1;
                if (pf_valid) begin
                  tx       <= pf_data;
                  pf_valid <= 1'b0;
                end else if (ack_fresh) begin
                  tx <= mem_rdata;
                end else begin
                  tx       <= 8'hFF;
                  underrun <= 1'b1;
                end
              end else begin
                tx <= {tx[6:0], 1'b1};
              end
            end
            if (!mem_req && !pf_valid) begin
              mem_req  <= 1'b1;
              mem_addr <= rd_addr;
            end
          end
          S_ID: begin
            if (sck_fall) begin
              fall_cnt <= fall_cnt + 3'd1;
              if (fall_cnt == 3'd0) begin
                unique case (id_idx)
                  2'd0:    tx <= JEDEC_ID[23:16];
                  2'd1:    tx <= JEDEC_ID[15:8];
                  2'd2:    tx <= JEDEC_ID[7:0];
                  default: tx <= 8'hFF;
                endcase
                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end else begin
                tx <= {tx[6:0], 1'b1};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: an SPI mode-0 master drives frames at
// clock/8 while a bench memory answers requests with a programmable latency.
module tb_qspi_flash_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        mem_req, mem_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy, underrun, bad_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 2;
  int n_underrun = 0;
  int n_badcmd   = 0;
  bit chk_oe = 1'b0, exp_oe = 1'b0, chk_noreq = 1'b0, chk_busy = 1'b0;
  logic [23:0] addr_log[$];
  logic [7:0]  rbytes[8];

  qspi_flash_responder #(.JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .underrun    (underrun),
    .bad_cmd     (bad_cmd)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < addr_log.size()) return {8'h00, addr_log[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: acks mem_lat cycles after a request is first seen, data = addr[7:0]^A5.
  initial begin
    int cnt;
    logic [23:0] held;
    cnt = 0;
    held = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) held = mem_addr;
        else check("mem_addr_stable", {8'h00, mem_addr}, {8'h00, held});
        if (cnt == mem_lat - 1) begin
          mem_ack = 1'b1;
          mem_rdata = mem_f(mem_addr);
          addr_log.push_back(mem_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle compare against the phase the stimulus says the frame is in.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (underrun) n_underrun++;
      if (bad_cmd) n_badcmd++;
      if (chk_oe)    check("miso_oe", {31'd0, spi_miso_oe}, {31'd0, exp_oe});
      if (chk_noreq) check("no_mem_req", {31'd0, mem_req}, 32'd0);
      if (chk_busy)  check("busy", {31'd0, busy}, 32'd1);
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (4) @(negedge clock);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (4) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], r);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, r);
      b[i] = r;
    end
  endtask

  task automatic frame_begin();
    @(negedge clock);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    addr_log.delete();
    n_underrun = 0;
    n_badcmd = 0;
    chk_busy = 1'b1;
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clock);
    chk_oe = 1'b0;
    chk_busy = 1'b0;
    spi_cs_n = 1'b1;
    repeat (30) @(negedge clock);
  endtask

  task automatic send_read_hdr(input logic [23:0] a);
    send_byte(8'h03);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic read_frame(input logic [23:0] a, input int n);
    logic [7:0] b;
    frame_begin();
    send_read_hdr(a);
    chk_oe = 1'b1;
    exp_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      rbytes[i] = b;
    end
    frame_end();
  endtask

  initial begin
    logic [7:0] b;
    logic r;
    reset = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_miso", {31'd0, spi_miso}, 32'd1);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    check("rst_mem_addr", {8'h00, mem_addr}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // READ at 0x001000, fast memory; literal bytes from the data sheet example.
    mem_lat = 2;
    read_frame(24'h001000, 4);
    check("read_b0", {24'd0, rbytes[0]}, 32'hA5);
    check("read_b1", {24'd0, rbytes[1]}, 32'hA4);
    check("read_b2", {24'd0, rbytes[2]}, 32'hA7);
    check("read_b3", {24'd0, rbytes[3]}, 32'hA6);
    for (int i = 0; i < 5; i++) check($sformatf("read_addr%0d", i), log_at(i), 32'h001000 + i);
    check("read_underrun", n_underrun, 0);

    // Address wrap at the top of the 24-bit space.
    read_frame(24'hFFFFFE, 3);
    check("wrap_b0", {24'd0, rbytes[0]}, {24'd0, mem_f(24'hFFFFFE)});
    check("wrap_b1", {24'd0, rbytes[1]}, {24'd0, mem_f(24'hFFFFFF)});
    check("wrap_b2", {24'd0, rbytes[2]}, {24'd0, mem_f(24'h000000)});
    check("wrap_addr0", log_at(0), 32'hFFFFFE);
    check("wrap_addr1", log_at(1), 32'hFFFFFF);
    check("wrap_addr2", log_at(2), 32'h000000);

    // READ-ID: three JEDEC bytes then 0xFF, no memory traffic.
    frame_begin();
    chk_noreq = 1'b1;
    send_byte(8'h9F);
    chk_oe = 1'b1;
    exp_oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      rbytes[i] = b;
    end
    frame_end();
    chk_noreq = 1'b0;
    check("id_b0", {24'd0, rbytes[0]}, 32'hEF);
    check("id_b1", {24'd0, rbytes[1]}, 32'h40);
    check("id_b2", {24'd0, rbytes[2]}, 32'h16);
    check("id_b3", {24'd0, rbytes[3]}, 32'hFF);
    check("id_bad_cmd", n_badcmd, 0);

    // Unsupported opcode: one bad_cmd pulse, bus stays released.
    frame_begin();
    chk_oe = 1'b1;
    exp_oe = 1'b0;
    send_byte(8'h0B);
    recv_byte(b);
    recv_byte(b);
    frame_end();
    check("bad_cmd_pulses", n_badcmd, 1);
    read_frame(24'h000080, 2);
    check("after_bad_b0", {24'd0, rbytes[0]}, {24'd0, mem_f(24'h000080)});
    check("after_bad_b1", {24'd0, rbytes[1]}, {24'd0, mem_f(24'h000081)});

    // Slow memory: the first byte cannot be ready, later ones can.
    mem_lat = 20;
    read_frame(24'h000230, 4);
    check("slow_b0", {24'd0, rbytes[0]}, 32'hFF);
    check("slow_b1", {24'd0, rbytes[1]}, 32'h94);
    check("slow_b2", {24'd0, rbytes[2]}, 32'h97);
    check("slow_b3", {24'd0, rbytes[3]}, 32'h96);
    check("slow_underrun", n_underrun, 1);
    check("slow_addr0", log_at(0), 32'h000230);
    check("slow_addr1", log_at(1), 32'h000231);

    // CS abort mid-address, then a clean READ.
    mem_lat = 2;
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    frame_end();
    check("abort_no_req", addr_log.size(), 0);
    read_frame(24'h000040, 2);
    check("abort_b0", {24'd0, rbytes[0]}, 32'hE5);
    check("abort_b1", {24'd0, rbytes[1]}, 32'hE4);

    // Reset during streaming with a request outstanding.
    mem_lat = 40;
    frame_begin();
    send_read_hdr(24'h000100);
    chk_oe = 1'b1;
    exp_oe = 1'b1;
    spi_bit(1'b0, r);
    spi_bit(1'b0, r);
    chk_oe = 1'b0;
    chk_busy = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("mid_rst_miso", {31'd0, spi_miso}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("post_rst_req", {31'd0, mem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
